// File: rtl/interval_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : interval_sequencer_pkg
// Brief   : Phase encodings and default widths for the interval sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package interval_sequencer_pkg;

    localparam int SEC_W_DEF   = 8;
    localparam int ROUND_W_DEF = 4;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_CALC = 3'd1,
        PH_WORK = 3'd2,
        PH_REST = 3'd3,
        PH_DONE = 3'd4
    } phase_e;

endpackage
`default_nettype wire

// File: rtl/interval_sequencer_sec_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : interval_sequencer_sec_prescaler
// Brief   : Divides clk down to a one-cycle tick per second while enabled.
// Rev     : 1.0  initial release
// ============================================================================
module interval_sequencer_sec_prescaler #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int c_CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TICKS_PER_SEC - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == c_LAST);
    assign o_tick = i_en & w_last;

    // Clear wins over enable so an abort inside an active phase restarts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/interval_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : interval_sequencer
// Brief   : Drives the duration calculator and runs the work/rest round schedule.
// Rev     : 1.0  initial release
// ============================================================================
module interval_sequencer
    import interval_sequencer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int SEC_W         = SEC_W_DEF,
    parameter int ROUND_W       = ROUND_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    input  logic [7:0]         cfg_bits,
    input  logic [ROUND_W-1:0] rounds,
    input  logic [SEC_W-1:0]   rest_sec,
    output logic [7:0]         calc_bits,
    input  logic [7:0]         calc_result,
    output logic [2:0]         phase,
    output logic [SEC_W-1:0]   sec_remaining,
    output logic [ROUND_W-1:0] round_num,
    output logic               sec_tick,
    output logic               busy,
    output logic               done,
    output logic               err
);

    phase_e             r_state,  w_state_nx;
    logic [7:0]         r_calc_bits, w_calc_bits_nx;
    logic [SEC_W-1:0]   r_work_sec,  w_work_sec_nx;
    logic [SEC_W-1:0]   r_rest_reg,  w_rest_reg_nx;
    logic [ROUND_W-1:0] r_rounds_reg, w_rounds_reg_nx;
    logic [SEC_W-1:0]   r_sec_rem,   w_sec_rem_nx;
    logic [ROUND_W-1:0] r_round,     w_round_nx;
    logic               r_err,       w_err_nx;

    logic w_active;
    logic w_tick;
    logic w_last_sec;

    assign w_active   = (r_state == PH_WORK) || (r_state == PH_REST);
    assign w_last_sec = (r_sec_rem == SEC_W'(1));

    interval_sequencer_sec_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_active && !pause),
        .i_clr  (abort || !w_active),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= PH_IDLE;
            r_calc_bits  <= '0;
            r_work_sec   <= '0;
            r_rest_reg   <= '0;
            r_rounds_reg <= '0;
            r_sec_rem    <= '0;
            r_round      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_calc_bits  <= w_calc_bits_nx;
            r_work_sec   <= w_work_sec_nx;
            r_rest_reg   <= w_rest_reg_nx;
            r_rounds_reg <= w_rounds_reg_nx;
            r_sec_rem    <= w_sec_rem_nx;
            r_round      <= w_round_nx;
            r_err        <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_calc_bits_nx  = r_calc_bits;
        w_work_sec_nx   = r_work_sec;
        w_rest_reg_nx   = r_rest_reg;
        w_rounds_reg_nx = r_rounds_reg;
        w_sec_rem_nx    = r_sec_rem;
        w_round_nx      = r_round;
        w_err_nx        = r_err;

        if (abort) begin
            w_state_nx   = PH_IDLE;
            w_sec_rem_nx = '0;
            w_round_nx   = '0;
        end else begin
            case (r_state)
                PH_IDLE: begin
                    if (start && (rounds != '0)) begin
                        w_calc_bits_nx  = cfg_bits;
                        w_rounds_reg_nx = rounds;
                        w_rest_reg_nx   = rest_sec;
                        w_err_nx        = 1'b0;
                        w_state_nx      = PH_CALC;
                    end
                end
                PH_CALC: begin
                    // Calculator has had one full cycle to settle on calc_bits.
                    w_work_sec_nx = SEC_W'(calc_result);
                    if (calc_result == 8'd0) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = PH_DONE;
                    end else begin
                        w_sec_rem_nx = SEC_W'(calc_result);
                        w_round_nx   = ROUND_W'(1);
                        w_state_nx   = PH_WORK;
                    end
                end
                PH_WORK: begin
                    if (w_tick) begin
                        if (!w_last_sec) begin
                            w_sec_rem_nx = r_sec_rem - SEC_W'(1);
                        end else if (r_round == r_rounds_reg) begin
                            w_state_nx = PH_DONE;
                        end else if (r_rest_reg != '0) begin
                            w_sec_rem_nx = r_rest_reg;
                            w_state_nx   = PH_REST;
                        end else begin
                            w_sec_rem_nx = r_work_sec;
                            w_round_nx   = r_round + ROUND_W'(1);
                        end
                    end
                end
                PH_REST: begin
                    if (w_tick) begin
                        if (!w_last_sec) begin
                            w_sec_rem_nx = r_sec_rem - SEC_W'(1);
                        end else begin
                            w_sec_rem_nx = r_work_sec;
                            w_round_nx   = r_round + ROUND_W'(1);
                            w_state_nx   = PH_WORK;
                        end
                    end
                end
                PH_DONE: begin
                    w_state_nx   = PH_IDLE;
                    w_sec_rem_nx = '0;
                    w_round_nx   = '0;
                end
                default: begin
                    w_state_nx   = PH_IDLE;
                    w_sec_rem_nx = '0;
                    w_round_nx   = '0;
                end
            endcase
        end
    end

    assign calc_bits     = r_calc_bits;
    assign phase         = r_state;
    assign sec_remaining = r_sec_rem;
    assign round_num     = r_round;
    assign sec_tick      = w_tick;
    assign busy          = (r_state != PH_IDLE);
    assign done          = (r_state == PH_DONE);
    assign err           = r_err;

endmodule
`default_nettype wire
